// File: rtl/wbu_pkg.sv
// Shared definitions for the write-back stage: load funct3 codes, FSM
// encoding and the holding-register layout used while a load is outstanding.
package wbu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [4:0] X0 = 5'd0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wb_state_t;

  // Destination and load-shape fields captured when a load has to wait.
  typedef struct packed {
    logic       wen;
    logic [4:0] addr;
    logic [2:0] funct3;
    logic [1:0] offset;
  } ld_hold_t;

endpackage

// File: rtl/wbu_if.sv
// Bundle between the memory-access stage / data memory and the write-back
// stage. master = upstream side, slave = wbu.
interface wbu_if;
  logic        i_rd_wen;
  logic [4:0]  i_rd_addr;
  logic        i_rd_mem;
  logic [2:0]  i_ld_funct3;
  logic [1:0]  i_ld_offset;
  logic [31:0] i_mem_data;
  logic        i_mem_rvalid;
  logic [31:0] i_alu_result;
  logic        o_rf_wen;
  logic [4:0]  o_rf_waddr;
  logic [31:0] o_rf_wdata;
  logic        o_stall;
  logic        o_fwd_valid;
  logic [4:0]  o_fwd_addr;
  logic [31:0] o_fwd_data;
  logic        o_ld_err;

  modport master (
    output i_rd_wen, i_rd_addr, i_rd_mem, i_ld_funct3, i_ld_offset,
           i_mem_data, i_mem_rvalid, i_alu_result,
    input  o_rf_wen, o_rf_waddr, o_rf_wdata, o_stall,
           o_fwd_valid, o_fwd_addr, o_fwd_data, o_ld_err
  );

  modport slave (
    input  i_rd_wen, i_rd_addr, i_rd_mem, i_ld_funct3, i_ld_offset,
           i_mem_data, i_mem_rvalid, i_alu_result,
    output o_rf_wen, o_rf_waddr, o_rf_wdata, o_stall,
           o_fwd_valid, o_fwd_addr, o_fwd_data, o_ld_err
  );
endinterface

// File: rtl/wbu_ld_align.sv
// Load data aligner: picks the addressed byte/halfword out of the raw word,
// extends it per funct3, and flags misaligned or illegal load types.
module wbu_ld_align
  import wbu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        err_o
);

  logic [31:0] byte_sh, half_sh;
  logic [7:0]  b;
  logic [15:0] h;

  assign byte_sh = data_i >> {offset_i, 3'b000};
  assign half_sh = data_i >> {offset_i[1], 4'b0000};
  assign b       = byte_sh[7:0];
  assign h       = half_sh[15:0];

  // Extension select and alignment/legality check.
  always_comb begin
    data_o = data_i;
    err_o  = 1'b0;
    case (funct3_i)
      F3_LB:  data_o = {{24{b[7]}}, b};
      F3_LBU: data_o = {24'h0, b};
      F3_LH:  begin data_o = {{16{h[15]}}, h}; err_o = offset_i[0]; end
      F3_LHU: begin data_o = {16'h0, h};       err_o = offset_i[0]; end
      F3_LW:  err_o = (offset_i != 2'b00);
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/wbu.sv
// Write-back stage: retires ALU results and loads to the register file,
// stalls upstream while a load waits on memory, times out dead loads and
// keeps a one-cycle forwarding copy of the last write.
module wbu
  import wbu_pkg::*;
#(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic clk_sys,
  input  logic rst_sys,
  wbu_if.slave bus
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(WAIT_MAX - 1);

  wb_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ld_hold_t         hold_q, hold_d;
  logic             fwd_valid_q;
  logic [4:0]       fwd_addr_q;
  logic [31:0]      fwd_data_q;
  logic             ld_err_q;

  logic        rf_wen, stall, err_evt;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [2:0]  cur_f3;
  logic [1:0]  cur_off;
  logic [31:0] al_data;
  logic        al_err;

  // While waiting the load shape comes from the holding registers, since
  // upstream may present a different instruction on i_rd_*.
  assign cur_f3  = (state_q == WAIT) ? hold_q.funct3 : bus.i_ld_funct3;
  assign cur_off = (state_q == WAIT) ? hold_q.offset : bus.i_ld_offset;

  wbu_ld_align u_align (
    .funct3_i (cur_f3),
    .offset_i (cur_off),
    .data_i   (bus.i_mem_data),
    .data_o   (al_data),
    .err_o    (al_err)
  );

  // Next state, write port and stall; outputs are forced quiet in reset.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    stall    = 1'b0;
    rf_wen   = 1'b0;
    rf_waddr = bus.i_rd_addr;
    rf_wdata = bus.i_alu_result;
    err_evt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.i_rd_mem) begin
          rf_wen = bus.i_rd_wen && (bus.i_rd_addr != X0);
        end else if (bus.i_mem_rvalid) begin
          rf_wdata = al_data;
          rf_wen   = bus.i_rd_wen && (bus.i_rd_addr != X0) && !al_err;
          err_evt  = al_err;
        end else begin
          stall   = 1'b1;
          hold_d  = '{wen: bus.i_rd_wen, addr: bus.i_rd_addr,
                      funct3: bus.i_ld_funct3, offset: bus.i_ld_offset};
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        rf_waddr = hold_q.addr;
        rf_wdata = al_data;
        if (bus.i_mem_rvalid) begin
          // rvalid on the timeout cycle still wins.
          rf_wen  = hold_q.wen && (hold_q.addr != X0) && !al_err;
          err_evt = al_err;
          state_d = IDLE;
        end else if (cnt_q == TMO) begin
          err_evt = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst_sys) begin
      rf_wen  = 1'b0;
      stall   = 1'b0;
      err_evt = 1'b0;
    end
  end

  // State, holding, forwarding and error-pulse registers.
  always_ff @(posedge clk_sys) begin
    if (!rst_sys) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
      ld_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      fwd_valid_q <= rf_wen;
      ld_err_q    <= err_evt;
      if (rf_wen) begin
        fwd_addr_q <= rf_waddr;
        fwd_data_q <= rf_wdata;
      end
    end
  end

  assign bus.o_rf_wen    = rf_wen;
  assign bus.o_rf_waddr  = rf_waddr;
  assign bus.o_rf_wdata  = rf_wdata;
  assign bus.o_stall     = stall;
  assign bus.o_fwd_valid = fwd_valid_q;
  assign bus.o_fwd_addr  = fwd_addr_q;
  assign bus.o_fwd_data  = fwd_data_q;
  assign bus.o_ld_err    = ld_err_q;

endmodule

// File: tb/tb_wbu.sv
// Directed + randomized bench for wbu. Loads are modelled as whole
// transactions (latency in cycles) against a plain-arithmetic alignment model.
module tb_wbu;

  localparam int WM = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wbu_if bus();

  wbu #(.WAIT_MAX(WM), .CNT_W(8)) dut (
    .clk_sys (clk),
    .rst_sys (rst),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [4:0]  m_fa = '0;
  logic [31:0] m_fd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void ref_ld(input logic [2:0] f3, input logic [1:0] off,
                                 input logic [31:0] d, output logic [31:0] v,
                                 output logic err);
    int unsigned byt, half;
    byt  = (d >> (8 * int'(off))) & 32'hFF;
    half = (d >> (16 * (int'(off) / 2))) & 32'hFFFF;
    v = 32'h0; err = 1'b0;
    case (f3)
      3'd0: v = byt + ((byt >= 128) ? 32'hFFFF_FF00 : 32'h0);
      3'd4: v = byt;
      3'd1: begin v = half + ((half >= 32768) ? 32'hFFFF_0000 : 32'h0); err = off[0]; end
      3'd5: begin v = half; err = off[0]; end
      3'd2: begin v = d; err = (off != 0); end
      default: err = 1'b1;
    endcase
  endfunction

  task automatic scramble_rd();
    bus.i_rd_wen     = 1'($urandom);
    bus.i_rd_addr    = 5'($urandom);
    bus.i_rd_mem     = 1'($urandom);
    bus.i_ld_funct3  = 3'($urandom);
    bus.i_ld_offset  = 2'($urandom);
    bus.i_alu_result = $urandom;
    bus.i_mem_data   = $urandom;
  endtask

  // One clock cycle: check combinational outputs mid-cycle, then registered
  // outputs just after the edge.
  task automatic cyc(input string tag, input logic ew, input logic [4:0] ea,
                     input logic [31:0] ed, input logic es, input logic eerr);
    #2;
    chk({tag, " stall"}, bus.o_stall, es);
    chk({tag, " rf_wen"}, bus.o_rf_wen, ew);
    if (ew) begin
      chk({tag, " waddr"}, bus.o_rf_waddr, ea);
      chk({tag, " wdata"}, bus.o_rf_wdata, ed);
    end
    @(posedge clk); #1;
    chk({tag, " fwd_valid"}, bus.o_fwd_valid, ew);
    if (ew) begin m_fa = ea; m_fd = ed; end
    chk({tag, " fwd_addr"}, bus.o_fwd_addr, m_fa);
    chk({tag, " fwd_data"}, bus.o_fwd_data, m_fd);
    chk({tag, " ld_err"}, bus.o_ld_err, eerr);
  endtask

  task automatic do_alu(input string tag, input logic wen, input logic [4:0] rd,
                        input logic [31:0] alu);
    bus.i_rd_wen = wen; bus.i_rd_addr = rd; bus.i_rd_mem = 1'b0;
    bus.i_alu_result = alu; bus.i_mem_rvalid = 1'($urandom);
    bus.i_mem_data = $urandom; bus.i_ld_funct3 = 3'($urandom);
    bus.i_ld_offset = 2'($urandom);
    cyc(tag, wen && (rd != 0), rd, alu, 1'b0, 1'b0);
  endtask

  // Load whose read data arrives lat cycles after it enters the stage.
  task automatic do_ld(input string tag, input logic wen, input logic [4:0] rd,
                       input logic [2:0] f3, input logic [1:0] off,
                       input logic [31:0] d, input int lat,
                       input logic [31:0] ev, input logic eerr);
    bus.i_rd_wen = wen; bus.i_rd_addr = rd; bus.i_rd_mem = 1'b1;
    bus.i_ld_funct3 = f3; bus.i_ld_offset = off; bus.i_alu_result = $urandom;
    for (int k = 0; k <= WM; k++) begin
      if (k > 0) scramble_rd();
      if (k == lat) begin
        bus.i_mem_rvalid = 1'b1; bus.i_mem_data = d;
        cyc(tag, wen && (rd != 0) && !eerr, rd, ev, 1'b0, eerr);
        break;
      end else if (k == WM) begin
        bus.i_mem_rvalid = 1'b0;
        cyc({tag, " tmo"}, 1'b0, rd, 32'h0, 1'b0, 1'b1);
      end else begin
        bus.i_mem_rvalid = 1'b0;
        cyc({tag, " wait"}, 1'b0, rd, 32'h0, 1'b1, 1'b0);
      end
    end
  endtask

  initial begin
    logic [31:0] v, d;
    logic        e;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [4:0]  rd;
    logic        wen;
    int          lat;

    // Reset: outputs quiet even with a write/load presented.
    bus.i_rd_wen = 1'b1; bus.i_rd_addr = 5'd5; bus.i_rd_mem = 1'b0;
    bus.i_ld_funct3 = 3'd2; bus.i_ld_offset = 2'd0; bus.i_mem_data = '0;
    bus.i_mem_rvalid = 1'b0; bus.i_alu_result = 32'hAAAA_5555;
    #2;
    chk("rst rf_wen", bus.o_rf_wen, 1'b0);
    bus.i_rd_mem = 1'b1;
    #1;
    chk("rst stall", bus.o_stall, 1'b0);
    @(posedge clk); #1;
    chk("rst fwd_valid", bus.o_fwd_valid, 1'b0);
    chk("rst fwd_addr", bus.o_fwd_addr, 32'h0);
    chk("rst fwd_data", bus.o_fwd_data, 32'h0);
    chk("rst ld_err", bus.o_ld_err, 1'b0);
    rst = 1'b1;

    do_alu("alu rd5", 1'b1, 5'd5, 32'h1234_5678);
    do_alu("x0", 1'b1, 5'd0, 32'hCAFE_F00D);
    do_alu("no wen", 1'b0, 5'd9, 32'h1111_2222);

    do_ld("LB3",  1'b1, 5'd1, 3'b000, 2'd3, 32'h80FF_7F01, 0, 32'hFFFF_FF80, 1'b0);
    do_ld("LBU1", 1'b1, 5'd2, 3'b100, 2'd1, 32'h80FF_7F01, 0, 32'h0000_007F, 1'b0);
    do_ld("LH2",  1'b1, 5'd3, 3'b001, 2'd2, 32'h80FF_7F01, 0, 32'hFFFF_80FF, 1'b0);
    do_ld("LHU0", 1'b1, 5'd4, 3'b101, 2'd0, 32'h80FF_7F01, 0, 32'h0000_7F01, 1'b0);
    do_ld("LW0",  1'b1, 5'd6, 3'b010, 2'd0, 32'h80FF_7F01, 0, 32'h80FF_7F01, 1'b0);

    do_ld("LW late3", 1'b1, 5'd7, 3'b010, 2'd0, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 1'b0);

    do_ld("LH mis", 1'b1, 5'd8, 3'b001, 2'd1, 32'h1234_5678, 0, 32'h0, 1'b1);
    do_ld("f3 ill", 1'b1, 5'd8, 3'b011, 2'd0, 32'h1234_5678, 0, 32'h0, 1'b1);
    do_ld("LW late-max", 1'b1, 5'd10, 3'b010, 2'd0, 32'h0BAD_F00D, WM, 32'h0BAD_F00D, 1'b0);
    do_ld("timeout", 1'b1, 5'd11, 3'b010, 2'd0, 32'h5555_AAAA, WM + 1, 32'h0, 1'b1);

    // Reset during the second WAIT cycle drops the load.
    bus.i_rd_wen = 1'b1; bus.i_rd_addr = 5'd12; bus.i_rd_mem = 1'b1;
    bus.i_ld_funct3 = 3'b010; bus.i_ld_offset = 2'd0; bus.i_mem_rvalid = 1'b0;
    cyc("rstw entry", 1'b0, 5'd12, 32'h0, 1'b1, 1'b0);
    cyc("rstw w1", 1'b0, 5'd12, 32'h0, 1'b1, 1'b0);
    rst = 1'b0;
    #2;
    chk("rstw stall", bus.o_stall, 1'b0);
    chk("rstw rf_wen", bus.o_rf_wen, 1'b0);
    @(posedge clk); #1;
    m_fa = '0; m_fd = '0;
    chk("rstw fwd_valid", bus.o_fwd_valid, 1'b0);
    chk("rstw fwd_data", bus.o_fwd_data, 32'h0);
    chk("rstw ld_err", bus.o_ld_err, 1'b0);
    rst = 1'b1;
    do_alu("post rst alu", 1'b1, 5'd9, 32'h0F0F_0F0F);

    // Randomized mix of ALU ops and loads of varied latency.
    for (int t = 0; t < 200; t++) begin
      wen = 1'($urandom);
      rd  = 5'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        do_alu("rnd alu", wen, rd, $urandom);
      end else begin
        f3  = 3'($urandom);
        off = 2'($urandom);
        d   = $urandom;
        lat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WM + 2))
                                          : int'($urandom_range(0, 3));
        ref_ld(f3, off, d, v, e);
        if (lat > WM) do_ld("rnd tmo", wen, rd, f3, off, d, lat, 32'h0, 1'b1);
        else          do_ld("rnd ld", wen, rd, f3, off, d, lat, v, e);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wbu.md
Name: wbu

Overview:
- Write-back stage directly downstream of the memory-access stage.
- Consumes that stage's registered destination info, ALU result and data-memory read data, and drives the single integer register-file write port.
- Supports variable-latency data memory through a read-valid handshake, stalling the pipeline while a load is outstanding.
- Performs load byte/halfword alignment and extension, detects misaligned or timed-out loads, and provides a one-cycle forwarding register for the read-after-write gap.

Parameters:
- WAIT_MAX, 16: maximum cycles spent in WAIT before a load is declared timed out (range 2..255).
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > WAIT_MAX.

Ports:
- clk_sys  in  1  system clock; all state updates on rising edge.
- rst_sys  in  1  reset, synchronous, active-low.
- i_rd_wen  in  1  instruction writes rd (registered by memory stage).
- i_rd_addr  in  5  destination register.
- i_rd_mem  in  1  instruction is a load; result comes from memory.
- i_ld_funct3  in  3  load type (LB/LH/LW/LBU/LHU).
- i_ld_offset  in  2  byte offset, address[1:0] of the load.
- i_mem_data  in  32  raw word read from data memory.
- i_mem_rvalid  in  1  i_mem_data valid this cycle.
- i_alu_result  in  32  registered ALU result.
- o_rf_wen  out  1  register-file write enable.
- o_rf_waddr  out  5  register-file write address.
- o_rf_wdata  out  32  register-file write data.
- o_stall  out  1  freeze upstream stages; the current wb-stage inputs are held.
- o_fwd_valid  out  1  forwarding register holds the previous-cycle write.
- o_fwd_addr  out  5  forwarded register address.
- o_fwd_data  out  32  forwarded data.
- o_ld_err  out  1  one-cycle pulse: misaligned, illegal-funct3 or timed-out load.

Behaviour:
- States: IDLE, WAIT.
- Reset values: state=IDLE, wait counter=0, o_fwd_valid=0, o_fwd_addr=0, o_fwd_data=0, o_ld_err=0, holding registers=0. Combinational outputs evaluate to o_rf_wen=0 and o_stall=0 while reset is asserted.

IDLE, non-load (i_rd_mem=0):
- Zero latency: o_rf_wen = i_rd_wen and (i_rd_addr != 0).
- o_rf_waddr = i_rd_addr; o_rf_wdata = i_alu_result.
- i_mem_rvalid is ignored.

IDLE, load (i_rd_mem=1), i_mem_rvalid=1:
- Retire the same cycle.
- Write data is the aligned result (rules below); write is suppressed if rd=x0 or on error.

IDLE, load, i_mem_rvalid=0:
- o_stall=1 combinationally in this cycle.
- Capture rd_wen, rd_addr, funct3 and offset into holding registers; clear the counter; next state WAIT.

WAIT:
- o_stall=1 and the counter increments each cycle. All fields come from the holding registers; the i_rd_* inputs are ignored.
- On i_mem_rvalid=1: retire with aligned data, o_stall=0 in that same cycle, next state IDLE.
- Timeout: if the counter reaches WAIT_MAX-1 with no rvalid, raise a 1-cycle o_ld_err, perform no write, set o_stall=0, next state IDLE.
- rvalid arriving exactly on the timeout cycle counts as a success; timeout is not flagged.

Alignment:
- Byte: b = data[8*offset +: 8].
- Halfword: h = data[16*offset[1] +: 16].
- LB: sign-extend b. LBU: zero-extend b. LH: sign-extend h. LHU: zero-extend h. LW: full word.

Errors (evaluated at retire):
- LH/LHU with offset[0]=1 is misaligned.
- LW with offset!=0 is misaligned.
- funct3 of 3, 6 or 7 is illegal.
- On any error: o_ld_err=1 for one cycle and o_rf_wen=0.

Forwarding register:
- Each cycle o_fwd_valid is registered from o_rf_wen.
- When o_rf_wen=1, o_fwd_addr and o_fwd_data capture o_rf_waddr and o_rf_wdata. Otherwise they hold their values.

Reset:
- Reset asserted during WAIT drops the outstanding load (no write, no error) and returns to IDLE.

Decomposition:
- Shared package:
  - funct3 constants: LB=3'b000, LH=3'b001, LW=3'b010, LBU=3'b100, LHU=3'b101.
  - wb state encoding: IDLE=1'b0, WAIT=1'b1.
  - Register index X0=5'd0.
- Sub-module ld_align: purely combinational. Inputs: funct3, offset, raw word. Outputs: aligned data and misalign/illegal flag.
- Flops use the existing reset-flop primitives where practical.

Test Plan:
- ALU write: i_rd_wen=1, rd=5, alu=0x1234_5678, i_rd_mem=0 -> same cycle o_rf_wen=1, waddr=5, wdata=0x12345678, o_stall=0. Next cycle fwd_valid=1, fwd_addr=5, fwd_data=0x12345678.
- x0 suppression: rd=0, i_rd_wen=1 -> o_rf_wen=0, and o_fwd_valid=0 next cycle.
- Immediate load alignment with mem=0x80FF_7F01, rvalid=1:
  - LB off=3 -> 0xFFFFFF80.
  - LBU off=1 -> 0x0000007F.
  - LH off=2 -> 0xFFFF80FF.
  - LHU off=0 -> 0x00007F01.
  - LW off=0 -> 0x80FF7F01.
- Delayed load: LW rd=7, rvalid arrives 3 cycles late with 0xDEADBEEF -> o_stall=1 for exactly 3 cycles (entry cycle included). On the 4th cycle stall=0, o_rf_wen=1, waddr=7, wdata=0xDEADBEEF. rd inputs changed during WAIT must not affect the write.
- Errors:
  - LH off=1, rvalid=1 -> o_ld_err=1 for one cycle, o_rf_wen=0.
  - funct3=3'b011 -> same response.
  - WAIT_MAX=16, no rvalid -> stall high for 16 cycles total, then o_ld_err pulses and no write occurs.
- Reset mid-WAIT: drive rst_sys=0 during cycle 2 of WAIT -> next cycle state IDLE, o_stall=0, no write, no o_ld_err. A subsequent ALU write retires normally.
